// File: rtl/game_pkg.sv
// Shared types and helpers for the game-flow controller.
// Holds the state enum, goal encodings, text_en bit positions and BCD helpers.
// Imported by game_text_ctrl and bcd_score_cnt.
package game_pkg;

    typedef enum logic [2:0] {
        ST_RULES,
        ST_SERVE,
        ST_PLAY,
        ST_GOAL,
        ST_OVER
    } state_t;

    localparam logic [1:0] GOAL_NONE = 2'b00;
    localparam logic [1:0] GOAL_P1   = 2'b01;
    localparam logic [1:0] GOAL_P2   = 2'b10;

    // Bit positions inside text_en, matching the overlay's {score, rule, goal} order.
    localparam int TXT_SCORE_BIT = 2;
    localparam int TXT_RULE_BIT  = 1;
    localparam int TXT_GOAL_BIT  = 0;

    // Binary (0..99) to packed two-digit BCD {tens, ones}; larger values clamp to 99.
    function automatic logic [7:0] bin_to_bcd2(input int unsigned v);
        int unsigned s;
        logic [3:0]  d1;
        logic [3:0]  d0;
        s  = (v > 99) ? 99 : v;
        d1 = 4'(s / 10);
        d0 = 4'(s % 10);
        return {d1, d0};
    endfunction

    // Packed two-digit BCD increment, saturating at 99.
    function automatic logic [7:0] bcd2_inc(input logic [7:0] v);
        if (v == 8'h99) begin
            return v;
        end else if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end else begin
            return {v[7:4], v[3:0] + 4'd1};
        end
    endfunction

endpackage

// File: rtl/bcd_score_cnt.sv
// Two-digit BCD score counter with synchronous clear and increment, saturating at 99.
// Ports: i_clk, i_reset_n (sync, active low), i_clear, i_inc -> o_dig1 (tens), o_dig0 (ones).
// Clear has priority over increment; outputs are registered.
module bcd_score_cnt
    import game_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_clear,
    input  logic       i_inc,
    output logic [3:0] o_dig1,
    output logic [3:0] o_dig0
);

    logic [7:0] r_score;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_score <= 8'h00;
        end else if (i_clear) begin
            r_score <= 8'h00;
        end else if (i_inc) begin
            r_score <= bcd2_inc(r_score);
        end
    end

    assign o_dig1 = r_score[7:4];
    assign o_dig0 = r_score[3:0];

endmodule

// File: rtl/game_text_ctrl.sv
// Game-flow FSM: sequences rules/serve/play/goal/over, owns both BCD scores and the goal banner.
// Ports: i_clk, i_reset_n, i_refresh_tick, i_btn_start, i_miss_p1/p2 -> BCD digits, o_goal,
//        o_text_en {score,rule,goal}, o_ball_run, o_ball_reset. All outputs registered.
module game_text_ctrl
    import game_pkg::*;
#(
    parameter int GOAL_FRAMES  = 120,
    parameter int SERVE_FRAMES = 60,
    parameter int WIN_SCORE    = 10
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_refresh_tick,
    input  logic       i_btn_start,
    input  logic       i_miss_p1,
    input  logic       i_miss_p2,
    output logic [3:0] o_p1_dig1,
    output logic [3:0] o_p1_dig0,
    output logic [3:0] o_p2_dig1,
    output logic [3:0] o_p2_dig0,
    output logic [1:0] o_goal,
    output logic [2:0] o_text_en,
    output logic       o_ball_run,
    output logic       o_ball_reset
);

    localparam logic [7:0] WIN_BCD    = bin_to_bcd2(WIN_SCORE);
    localparam logic [7:0] GOAL_LAST  = 8'(GOAL_FRAMES - 1);
    localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);

    state_t     r_state, w_state_nxt;
    logic       r_btn_prev;
    logic [7:0] r_frame_cnt;
    logic [1:0] r_goal, w_goal_nxt;
    logic       r_ball_reset, w_ball_reset_nxt;
    logic [2:0] r_text_en, w_text_en_nxt;
    logic       r_ball_run, w_ball_run_nxt;

    logic       w_start;
    logic       w_p1_inc, w_p2_inc, w_score_clr;
    logic       w_p1_win, w_p2_win;

    // Held-through-reset button is not an edge because r_btn_prev resets high.
    assign w_start = i_btn_start & ~r_btn_prev;

    // A simultaneous double miss is treated as no event at all.
    assign w_p1_inc    = (r_state == ST_PLAY) && i_miss_p2 && !i_miss_p1;
    assign w_p2_inc    = (r_state == ST_PLAY) && i_miss_p1 && !i_miss_p2;
    assign w_score_clr = (r_state == ST_RULES) && w_start;

    // Win check looks at the score the increment is about to produce.
    assign w_p1_win = (bcd2_inc({o_p1_dig1, o_p1_dig0}) == WIN_BCD);
    assign w_p2_win = (bcd2_inc({o_p2_dig1, o_p2_dig0}) == WIN_BCD);

    bcd_score_cnt u_p1_score (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_clear   (w_score_clr),
        .i_inc     (w_p1_inc),
        .o_dig1    (o_p1_dig1),
        .o_dig0    (o_p1_dig0)
    );

    bcd_score_cnt u_p2_score (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_clear   (w_score_clr),
        .i_inc     (w_p2_inc),
        .o_dig1    (o_p2_dig1),
        .o_dig0    (o_p2_dig0)
    );

    always_comb begin
        w_state_nxt      = r_state;
        w_goal_nxt       = r_goal;
        w_ball_reset_nxt = 1'b0;
        unique case (r_state)
            ST_RULES: begin
                if (w_start) begin
                    w_state_nxt      = ST_SERVE;
                    w_ball_reset_nxt = 1'b1;
                end
            end
            ST_SERVE: begin
                if (i_refresh_tick && r_frame_cnt == SERVE_LAST) begin
                    w_state_nxt = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (w_p1_inc) begin
                    w_goal_nxt  = GOAL_P1;
                    w_state_nxt = w_p1_win ? ST_OVER : ST_GOAL;
                end else if (w_p2_inc) begin
                    w_goal_nxt  = GOAL_P2;
                    w_state_nxt = w_p2_win ? ST_OVER : ST_GOAL;
                end
            end
            ST_GOAL: begin
                if (i_refresh_tick && r_frame_cnt == GOAL_LAST) begin
                    w_goal_nxt       = GOAL_NONE;
                    w_state_nxt      = ST_SERVE;
                    w_ball_reset_nxt = 1'b1;
                end
            end
            ST_OVER: begin
                if (w_start) begin
                    w_goal_nxt  = GOAL_NONE;
                    w_state_nxt = ST_RULES;
                end
            end
            default: begin
                w_state_nxt = ST_RULES;
                w_goal_nxt  = GOAL_NONE;
            end
        endcase
    end

    // Overlay enables and ball_run are decoded from the next state so they land with it.
    always_comb begin
        w_text_en_nxt  = 3'b000;
        w_ball_run_nxt = 1'b0;
        unique case (w_state_nxt)
            ST_RULES: begin
                w_text_en_nxt[TXT_SCORE_BIT] = 1'b1;
                w_text_en_nxt[TXT_RULE_BIT]  = 1'b1;
            end
            ST_SERVE: w_text_en_nxt[TXT_SCORE_BIT] = 1'b1;
            ST_PLAY: begin
                w_text_en_nxt[TXT_SCORE_BIT] = 1'b1;
                w_ball_run_nxt               = 1'b1;
            end
            ST_GOAL, ST_OVER: begin
                w_text_en_nxt[TXT_SCORE_BIT] = 1'b1;
                w_text_en_nxt[TXT_GOAL_BIT]  = 1'b1;
            end
            default: w_text_en_nxt = 3'b000;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state      <= ST_RULES;
            r_btn_prev   <= 1'b1;
            r_frame_cnt  <= 8'd0;
            r_goal       <= GOAL_NONE;
            r_ball_reset <= 1'b0;
            r_text_en    <= 3'b110;
            r_ball_run   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_btn_prev   <= i_btn_start;
            r_goal       <= w_goal_nxt;
            r_ball_reset <= w_ball_reset_nxt;
            r_text_en    <= w_text_en_nxt;
            r_ball_run   <= w_ball_run_nxt;
            // Clearing on entry means a tick coincident with the transition is not counted.
            if (w_state_nxt != r_state) begin
                r_frame_cnt <= 8'd0;
            end else if (i_refresh_tick) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

    assign o_goal       = r_goal;
    assign o_ball_reset = r_ball_reset;
    assign o_text_en    = r_text_en;
    assign o_ball_run   = r_ball_run;

endmodule

// File: tb/tb_game_text_ctrl.sv
// Directed bench for game_text_ctrl with default parameters (goal 120, serve 60, win 10).
module tb_game_text_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       tick = 1'b0;
    logic       btn = 1'b1;
    logic       miss_p1 = 1'b0;
    logic       miss_p2 = 1'b0;
    logic [3:0] p1_d1, p1_d0, p2_d1, p2_d0;
    logic [1:0] goal;
    logic [2:0] text_en;
    logic       ball_run, ball_reset;

    int n_chk  = 0;
    int n_pass = 0;

    game_text_ctrl dut (
        .i_clk          (clk),
        .i_reset_n      (reset_n),
        .i_refresh_tick (tick),
        .i_btn_start    (btn),
        .i_miss_p1      (miss_p1),
        .i_miss_p2      (miss_p2),
        .o_p1_dig1      (p1_d1),
        .o_p1_dig0      (p1_d0),
        .o_p2_dig1      (p2_d1),
        .o_p2_dig0      (p2_d0),
        .o_goal         (goal),
        .o_text_en      (text_en),
        .o_ball_run     (ball_run),
        .o_ball_reset   (ball_reset)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk = n_chk + 1;
        if (got === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock; inputs set before this are sampled at its edge, outputs read 1 ns later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        tick = 1'b1;
        repeat (n) cyc();
        tick = 1'b0;
    endtask

    task automatic start_edge();
        btn = 1'b0;
        cyc();
        btn = 1'b1;
        cyc();
    endtask

    initial begin
        // Reset with button held high, then hold 10 cycles.
        cyc();
        cyc();
        chk("rst_text_en", {5'd0, text_en}, 8'h06);
        chk("rst_goal", {6'd0, goal}, 8'h00);
        chk("rst_ball_reset", {7'd0, ball_reset}, 8'h00);
        reset_n = 1'b1;
        repeat (10) cyc();
        chk("held_btn_text_en", {5'd0, text_en}, 8'h06);
        chk("held_btn_run", {7'd0, ball_run}, 8'h00);
        chk("held_btn_p1", {p1_d1, p1_d0}, 8'h00);
        chk("held_btn_p2", {p2_d1, p2_d0}, 8'h00);

        // Start edge with a coincident tick that must not be counted.
        btn = 1'b0;
        cyc();
        btn = 1'b1;
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        chk("serve_ball_reset", {7'd0, ball_reset}, 8'h01);
        chk("serve_text_en", {5'd0, text_en}, 8'h04);
        cyc();
        chk("serve_ball_reset_drop", {7'd0, ball_reset}, 8'h00);
        ticks(59);
        chk("serve_59_run", {7'd0, ball_run}, 8'h00);
        ticks(1);
        chk("serve_60_run", {7'd0, ball_run}, 8'h01);
        chk("play_text_en", {5'd0, text_en}, 8'h04);

        // P1 misses: P2 scores.
        miss_p1 = 1'b1;
        cyc();
        miss_p1 = 1'b0;
        chk("p2_goal_score", {p2_d1, p2_d0}, 8'h01);
        chk("p2_goal_goal", {6'd0, goal}, 8'h02);
        chk("p2_goal_text_en", {5'd0, text_en}, 8'h05);
        chk("p2_goal_run", {7'd0, ball_run}, 8'h00);
        miss_p2 = 1'b1;
        cyc();
        miss_p2 = 1'b0;
        chk("goal_miss_ignored", {p1_d1, p1_d0}, 8'h00);
        ticks(119);
        chk("goal_119_goal", {6'd0, goal}, 8'h02);
        ticks(1);
        chk("goal_120_goal", {6'd0, goal}, 8'h00);
        chk("goal_120_ball_reset", {7'd0, ball_reset}, 8'h01);
        chk("goal_120_text_en", {5'd0, text_en}, 8'h04);
        cyc();
        chk("goal_ball_reset_drop", {7'd0, ball_reset}, 8'h00);

        // Double miss in PLAY is ignored.
        ticks(60);
        miss_p1 = 1'b1;
        miss_p2 = 1'b1;
        cyc();
        miss_p1 = 1'b0;
        miss_p2 = 1'b0;
        chk("dbl_miss_p1", {p1_d1, p1_d0}, 8'h00);
        chk("dbl_miss_p2", {p2_d1, p2_d0}, 8'h01);
        chk("dbl_miss_run", {7'd0, ball_run}, 8'h01);
        chk("dbl_miss_goal", {6'd0, goal}, 8'h00);

        // P1 scores nine times, returning to PLAY each time.
        for (int i = 0; i < 9; i++) begin
            miss_p2 = 1'b1;
            cyc();
            miss_p2 = 1'b0;
            ticks(120);
            ticks(60);
        end
        chk("p1_at_09", {p1_d1, p1_d0}, 8'h09);
        chk("p1_at_09_run", {7'd0, ball_run}, 8'h01);

        // Tenth point carries the BCD and wins.
        miss_p2 = 1'b1;
        cyc();
        miss_p2 = 1'b0;
        chk("win_p1_score", {p1_d1, p1_d0}, 8'h10);
        chk("win_goal", {6'd0, goal}, 8'h01);
        chk("win_text_en", {5'd0, text_en}, 8'h05);
        chk("win_run", {7'd0, ball_run}, 8'h00);
        ticks(120);
        chk("over_holds_goal", {6'd0, goal}, 8'h01);
        chk("over_holds_text_en", {5'd0, text_en}, 8'h05);
        miss_p1 = 1'b1;
        cyc();
        miss_p1 = 1'b0;
        chk("over_miss_ignored", {p2_d1, p2_d0}, 8'h01);

        // OVER -> RULES keeps scores; next start clears them.
        start_edge();
        chk("rules_text_en", {5'd0, text_en}, 8'h06);
        chk("rules_goal", {6'd0, goal}, 8'h00);
        chk("rules_p1_kept", {p1_d1, p1_d0}, 8'h10);
        start_edge();
        chk("restart_p1", {p1_d1, p1_d0}, 8'h00);
        chk("restart_p2", {p2_d1, p2_d0}, 8'h00);
        chk("restart_ball_reset", {7'd0, ball_reset}, 8'h01);
        chk("restart_text_en", {5'd0, text_en}, 8'h04);

        // Reset during GOAL.
        ticks(60);
        miss_p1 = 1'b1;
        cyc();
        miss_p1 = 1'b0;
        chk("pre_rst_goal", {6'd0, goal}, 8'h02);
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        chk("mid_rst_text_en", {5'd0, text_en}, 8'h06);
        chk("mid_rst_goal", {6'd0, goal}, 8'h00);
        chk("mid_rst_p2", {p2_d1, p2_d0}, 8'h00);
        chk("mid_rst_run", {7'd0, ball_run}, 8'h00);
        cyc();
        chk("mid_rst_held_btn", {5'd0, text_en}, 8'h06);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
